// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, runs the IMEM req/ack handshake and
// keeps one fetched instruction plus its PC+1 for the fetch/decode register.
//
// state | meaning
// BOOT  | first cycle out of reset, no request issued
// READY | no request outstanding; fetch when the output slot is free
// BUSY  | request outstanding, its data will fill the buffer
// DROP  | request outstanding but squashed by a redirect; data is discarded
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        StallF,
    input  logic        BranchD,
    input  logic [31:0] BranchTargetD,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemAck,
    input  logic [31:0] IMemRData,
    output logic [31:0] PCp1F,
    output logic [31:0] InstrF,
    output logic        ValidF
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        READY = 2'd1,
        BUSY  = 2'd2,
        DROP  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [31:0] pc;
    logic [31:0] pc_nxt;
    logic [31:0] req_addr;
    logic [31:0] req_addr_nxt;
    logic [31:0] instr;
    logic [31:0] instr_nxt;
    logic [31:0] pcp1;
    logic [31:0] pcp1_nxt;
    logic        valid;
    logic        valid_nxt;

    logic        req_c;
    logic [31:0] addr_c;
    logic        take;
    logic        slot_free;
    logic [31:0] pc_inc;
    logic [31:0] req_inc;

    assign take      = valid & ~StallF;
    assign slot_free = ~valid | take;
    assign pc_inc    = pc + 32'd1;
    assign req_inc   = req_addr + 32'd1;

    // Reset gates the request directly so an abandoned transfer stops at once.
    assign IMemReq  = req_c & RSTN;
    assign IMemAddr = addr_c;
    assign PCp1F    = pcp1;
    assign InstrF   = instr;
    assign ValidF   = valid;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state    <= BOOT;
            pc       <= RESET_PC;
            req_addr <= 32'd0;
            instr    <= 32'd0;
            pcp1     <= 32'd0;
            valid    <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            req_addr <= req_addr_nxt;
            instr    <= instr_nxt;
            pcp1     <= pcp1_nxt;
            valid    <= valid_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        req_addr_nxt = req_addr;
        instr_nxt    = instr;
        pcp1_nxt     = pcp1;
        valid_nxt    = valid;
        req_c        = 1'b0;
        addr_c       = pc;

        unique case (state)
            BOOT: begin
                state_nxt = READY;
                if (BranchD) begin
                    pc_nxt = BranchTargetD;
                end
            end

            READY: begin
                if (BranchD) begin
                    pc_nxt    = BranchTargetD;
                    valid_nxt = 1'b0;
                end else if (slot_free) begin
                    req_c        = 1'b1;
                    addr_c       = pc;
                    req_addr_nxt = pc;
                    if (IMemAck) begin
                        instr_nxt = IMemRData;
                        pcp1_nxt  = pc_inc;
                        valid_nxt = 1'b1;
                        pc_nxt    = pc_inc;
                    end else begin
                        if (take) begin
                            valid_nxt = 1'b0;
                        end
                        state_nxt = BUSY;
                    end
                end
            end

            BUSY: begin
                req_c  = 1'b1;
                addr_c = req_addr;
                if (BranchD) begin
                    pc_nxt    = BranchTargetD;
                    state_nxt = IMemAck ? READY : DROP;
                end else if (IMemAck) begin
                    instr_nxt = IMemRData;
                    pcp1_nxt  = req_inc;
                    valid_nxt = 1'b1;
                    pc_nxt    = req_inc;
                    state_nxt = READY;
                end
            end

            DROP: begin
                req_c  = 1'b1;
                addr_c = req_addr;
                if (BranchD) begin
                    pc_nxt = BranchTargetD;
                end
                if (IMemAck) begin
                    state_nxt = READY;
                end
            end

            default: begin
                state_nxt = BOOT;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a scoreboard of expected acked addresses and
// consumed buffer entries, checked by a free-running monitor.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        StallF;
    logic        BranchD;
    logic [31:0] BranchTargetD;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemAck = 1'b0;
    logic [31:0] IMemRData = 32'd0;
    logic [31:0] PCp1F;
    logic [31:0] InstrF;
    logic        ValidF;

    int tests = 0;
    int fails = 0;
    int lat   = 0;
    int cnt   = 0;
    bit poison = 1'b0;

    logic [31:0] exp_addr[$];
    logic [63:0] exp_out[$];

    logic        pending = 1'b0;
    logic [31:0] pend_addr = 32'd0;

    always #5 CLK = ~CLK;

    fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .CLK           (CLK),
        .RSTN          (RSTN),
        .StallF        (StallF),
        .BranchD       (BranchD),
        .BranchTargetD (BranchTargetD),
        .IMemReq       (IMemReq),
        .IMemAddr      (IMemAddr),
        .IMemAck       (IMemAck),
        .IMemRData     (IMemRData),
        .PCp1F         (PCp1F),
        .InstrF        (InstrF),
        .ValidF        (ValidF)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic push_entry(input logic [31:0] a, input logic [31:0] p1);
        exp_out.push_back({mem_word(a), p1});
    endtask

    // Memory: acks after 'lat' wait cycles, tolerates a request vanishing mid-way.
    always @(posedge CLK) begin
        #2;
        if (IMemReq) begin
            if (cnt >= lat) begin
                IMemAck   = 1'b1;
                IMemRData = poison ? 32'hDEAD_BEEF : mem_word(IMemAddr);
                cnt       = 0;
            end else begin
                IMemAck   = 1'b0;
                IMemRData = 32'd0;
                cnt++;
            end
        end else begin
            IMemAck = 1'b0;
            cnt     = 0;
        end
    end

    always @(negedge CLK) begin
        if (RSTN && pending) begin
            chk("req_held", {31'd0, IMemReq}, 32'd1);
            chk("addr_held", IMemAddr, pend_addr);
        end
        pending   = RSTN && IMemReq && !IMemAck;
        pend_addr = IMemAddr;

        if (RSTN && IMemReq && IMemAck) begin
            if (exp_addr.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL ack_addr: got unexpected ack at %h, expected none", IMemAddr);
            end else begin
                chk("ack_addr", IMemAddr, exp_addr.pop_front());
            end
        end

        if (RSTN && ValidF && !StallF && !BranchD) begin
            if (exp_out.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL take_extra: got %h/%h, expected no entry", InstrF, PCp1F);
            end else begin
                logic [63:0] e;
                e = exp_out.pop_front();
                chk("take_instr", InstrF, e[63:32]);
                chk("take_pcp1", PCp1F, e[31:0]);
            end
        end
    end

    initial begin
        RSTN          = 1'b0;
        StallF        = 1'b0;
        BranchD       = 1'b0;
        BranchTargetD = 32'd0;
        #3;
        chk("rst_req", {31'd0, IMemReq}, 32'd0);
        chk("rst_valid", {31'd0, ValidF}, 32'd0);
        chk("rst_instr", InstrF, 32'd0);
        chk("rst_pcp1", PCp1F, 32'd0);

        // Boot at 0x100, back-to-back zero-wait fetches
        repeat (2) @(posedge CLK);
        #1;
        RSTN = 1'b1;
        exp_addr.push_back(32'h100);
        exp_addr.push_back(32'h101);
        exp_addr.push_back(32'h102);
        push_entry(32'h100, 32'h101);
        push_entry(32'h101, 32'h102);
        cyc(1);
        chk("boot_valid", {31'd0, ValidF}, 32'd0);
        @(negedge CLK);
        chk("boot_req", {31'd0, IMemReq}, 32'd1);
        chk("boot_addr", IMemAddr, 32'h100);
        cyc(1);
        chk("first_valid", {31'd0, ValidF}, 32'd1);
        chk("first_pcp1", PCp1F, 32'h101);
        @(negedge CLK);
        chk("second_addr", IMemAddr, 32'h101);
        cyc(1);

        // Stall with a full buffer
        StallF = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("stall_req", {31'd0, IMemReq}, 32'd0);
            chk("stall_pcp1", PCp1F, 32'h102);
            chk("stall_instr", InstrF, mem_word(32'h101));
            cyc(1);
        end
        StallF = 1'b0;
        @(negedge CLK);
        chk("unstall_req", {31'd0, IMemReq}, 32'd1);
        chk("unstall_addr", IMemAddr, 32'h102);
        cyc(1);

        // Three wait states at 0x20
        StallF        = 1'b1;
        BranchD       = 1'b1;
        BranchTargetD = 32'h20;
        lat           = 3;
        exp_addr.push_back(32'h20);
        cyc(1);
        BranchD = 1'b0;
        StallF  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("wait_req", {31'd0, IMemReq}, 32'd1);
            chk("wait_addr", IMemAddr, 32'h20);
            chk("wait_valid", {31'd0, ValidF}, 32'd0);
            cyc(1);
        end
        chk("wait_fill_valid", {31'd0, ValidF}, 32'd1);
        chk("wait_fill_pcp1", PCp1F, 32'h21);

        // Redirect while the 0x20 request is in flight
        StallF        = 1'b1;
        BranchD       = 1'b1;
        BranchTargetD = 32'h20;
        lat           = 2;
        poison        = 1'b1;
        exp_addr.push_back(32'h20);
        exp_addr.push_back(32'h400);
        push_entry(32'h400, 32'h401);
        cyc(1);
        BranchD = 1'b0;
        StallF  = 1'b0;
        cyc(1);
        BranchD       = 1'b1;
        BranchTargetD = 32'h400;
        cyc(1);
        BranchD = 1'b0;
        cyc(1);
        chk("squash_valid", {31'd0, ValidF}, 32'd0);
        poison = 1'b0;
        lat    = 0;
        @(negedge CLK);
        chk("redir_req", {31'd0, IMemReq}, 32'd1);
        chk("redir_addr", IMemAddr, 32'h400);
        cyc(1);

        // Redirect coinciding with ack, then a double redirect in DROP
        lat    = 1;
        poison = 1'b1;
        exp_addr.push_back(32'h401);
        exp_addr.push_back(32'h300);
        exp_addr.push_back(32'h500);
        cyc(1);
        BranchD       = 1'b1;
        BranchTargetD = 32'h300;
        cyc(1);
        BranchD = 1'b0;
        lat     = 2;
        chk("same_ack_valid", {31'd0, ValidF}, 32'd0);
        cyc(1);
        BranchD       = 1'b1;
        BranchTargetD = 32'h400;
        cyc(1);
        BranchTargetD = 32'h500;
        cyc(1);
        BranchD = 1'b0;
        poison  = 1'b0;
        lat     = 0;
        chk("drop_valid", {31'd0, ValidF}, 32'd0);
        @(negedge CLK);
        chk("double_redir_addr", IMemAddr, 32'h500);
        cyc(1);
        chk("fill_500_valid", {31'd0, ValidF}, 32'd1);
        chk("fill_500_pcp1", PCp1F, 32'h501);
        chk("fill_500_instr", InstrF, mem_word(32'h500));

        // PC wrap at 0xFFFFFFFF
        StallF        = 1'b1;
        BranchD       = 1'b1;
        BranchTargetD = 32'hFFFF_FFFF;
        exp_addr.push_back(32'hFFFF_FFFF);
        exp_addr.push_back(32'h0);
        push_entry(32'hFFFF_FFFF, 32'h0);
        push_entry(32'h0, 32'h1);
        cyc(1);
        BranchD = 1'b0;
        StallF  = 1'b0;
        cyc(1);
        chk("wrap_valid", {31'd0, ValidF}, 32'd1);
        chk("wrap_pcp1", PCp1F, 32'h0);
        cyc(1);
        chk("after_wrap_pcp1", PCp1F, 32'h1);
        lat = 5;
        cyc(1);

        // Asynchronous reset in the middle of BUSY
        #2;
        chk("busy_req", {31'd0, IMemReq}, 32'd1);
        RSTN = 1'b0;
        #1;
        chk("async_req", {31'd0, IMemReq}, 32'd0);
        chk("async_valid", {31'd0, ValidF}, 32'd0);
        chk("async_pcp1", PCp1F, 32'd0);
        chk("async_instr", InstrF, 32'd0);
        lat    = 0;
        StallF = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RSTN = 1'b1;
        exp_addr.push_back(32'h100);
        cyc(1);
        @(negedge CLK);
        chk("reboot_addr", IMemAddr, 32'h100);
        cyc(1);
        chk("reboot_valid", {31'd0, ValidF}, 32'd1);
        chk("reboot_pcp1", PCp1F, 32'h101);
        @(negedge CLK);
        chk("reboot_stall_req", {31'd0, IMemReq}, 32'd0);
        cyc(1);

        chk("addr_q_left", exp_addr.size(), 32'd0);
        chk("out_q_left", exp_out.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
